// File: rtl/egg_ctrl_pkg.sv
// Shared state encoding and default round parameters for the egg lifecycle controller.
package egg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN_WAIT = 3'd1,
    ACTIVE     = 3'd2,
    GAME_OVER  = 3'd3
  } state_e;

  localparam int unsigned DEF_LIFETIME_TICKS = 600;
  localparam int unsigned DEF_RESPAWN_TICKS  = 60;
  localparam int unsigned DEF_LIVES          = 3;
  localparam int unsigned DEF_TIMER_W        = 10;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter advancing on tick; terminal_o flags the tick that finds the count at 1.
module tick_down_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic         pause_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         terminal_o
);

  logic [W-1:0] count_q, count_d;
  logic         step;

  // A zero count is idle: it never steps and never raises terminal.
  assign step       = tick_i && !pause_i && (count_q != '0);
  assign terminal_o = step && (count_q == W'(1));
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (step && !terminal_o) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/egg_lifecycle_ctrl.sv
// Egg round sequencer: spawn delay, active lifetime, collection, expiry, lives and game over.
// Optional blink warning near expiry is enabled by defining EGG_BLINK_EN.
module egg_lifecycle_ctrl
  import egg_ctrl_pkg::*;
#(
  parameter int unsigned LIFETIME_TICKS = DEF_LIFETIME_TICKS,
  parameter int unsigned RESPAWN_TICKS  = DEF_RESPAWN_TICKS,
  parameter int unsigned LIVES          = DEF_LIVES,
  parameter int unsigned TIMER_W        = DEF_TIMER_W
`ifdef EGG_BLINK_EN
  ,
  parameter int unsigned WARN_TICKS     = 120,
  parameter int unsigned BLINK_TICKS    = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               overlap,
  output logic               egg_visible,
  output logic               relocate,
  output logic               score_inc,
  output logic               score_clr,
  output logic [2:0]         lives,
  output logic               game_over,
  output logic [TIMER_W-1:0] time_left,
  output logic [2:0]         state_o
);

  localparam logic [TIMER_W-1:0] LIFE_V  = TIMER_W'(LIFETIME_TICKS);
  localparam logic [TIMER_W-1:0] RESP_V  = TIMER_W'(RESPAWN_TICKS);
  localparam logic [2:0]         LIVES_V = 3'(LIVES);

  state_e       state_q, state_d;
  logic [2:0]   lives_q, lives_d;
  logic         vis_q, vis_d;
  logic         go_q, go_d;
  logic         reloc_q, reloc_d;
  logic         inc_q, inc_d;
  logic         clr_q, clr_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_term;
  logic               collect;
  logic               blink_tog;

  tick_down_counter #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick),
    .pause_i    (pause),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count),
    .terminal_o (tmr_term)
  );

  assign collect = (state_q == ACTIVE) && overlap && !pause;

`ifdef EGG_BLINK_EN
  logic [15:0] blink_q;
  logic        in_warn;

  assign in_warn   = (state_q == ACTIVE) && tick && !pause &&
                     (tmr_count <= TIMER_W'(WARN_TICKS));
  assign blink_tog = in_warn && (blink_q == 16'(BLINK_TICKS - 1));

  // Counter restarts whenever the egg is not active, so each lifetime blinks from visible.
  always_ff @(posedge clk) begin
    if (rst || (state_q != ACTIVE)) begin
      blink_q <= '0;
    end else if (in_warn) begin
      blink_q <= blink_tog ? 16'd0 : blink_q + 16'd1;
    end
  end
`else
  assign blink_tog = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    vis_d    = vis_q;
    go_d     = go_q;
    reloc_d  = 1'b0;
    inc_d    = 1'b0;
    clr_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = RESP_V;

    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d  = SPAWN_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RESP_V;
          lives_d  = LIVES_V;
          clr_d    = 1'b1;
          go_d     = 1'b0;
          vis_d    = 1'b0;
        end
      end

      SPAWN_WAIT: begin
        vis_d = 1'b0;
        if (tmr_term) begin
          state_d  = ACTIVE;
          tmr_load = 1'b1;
          tmr_val  = LIFE_V;
          vis_d    = 1'b1;
        end
      end

      ACTIVE: begin
        if (blink_tog) vis_d = ~vis_q;
        // Collection takes priority over an expiry landing on the same edge.
        if (collect) begin
          inc_d    = 1'b1;
          reloc_d  = 1'b1;
          vis_d    = 1'b0;
          state_d  = SPAWN_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RESP_V;
        end else if (tmr_term) begin
          vis_d = 1'b0;
          if (lives_q > 3'd1) begin
            lives_d  = lives_q - 3'd1;
            reloc_d  = 1'b1;
            state_d  = SPAWN_WAIT;
            tmr_load = 1'b1;
            tmr_val  = RESP_V;
          end else begin
            lives_d  = 3'd0;
            go_d     = 1'b1;
            state_d  = GAME_OVER;
            tmr_load = 1'b1;
            tmr_val  = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lives_q <= LIVES_V;
      vis_q   <= 1'b0;
      go_q    <= 1'b0;
      reloc_q <= 1'b0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      vis_q   <= vis_d;
      go_q    <= go_d;
      reloc_q <= reloc_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
    end
  end

  assign egg_visible = vis_q;
  assign relocate    = reloc_q;
  assign score_inc   = inc_q;
  assign score_clr   = clr_q;
  assign lives       = lives_q;
  assign game_over   = go_q;
  assign time_left   = tmr_count;
  assign state_o     = state_q;

endmodule
